// File: rtl/gcd_job_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gcd_job_arbiter_if
//  Purpose  : Groups the requester-side and core-side signals of the GCD job
//             arbiter into one bundle.
//  Ports    : req/req_a/req_b        requester levels and packed operands
//             gnt/rsp_valid          one-hot grant and response pulses
//             rsp_data/rsp_err       result and error flag, valid with rsp_valid
//             busy                   arbiter not idle
//             core_rst_n/core_start  control of the shared GCD core
//             core_x/core_y          operands to the core
//             core_done/core_result  completion and result from the core
//  Modports : slave  - the arbiter
//             master - requesters plus core (the environment)
//  Revision : 1.0  initial release
// ============================================================================
interface gcd_job_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_err;
  logic                   busy;
  logic                   core_rst_n;
  logic                   core_start;
  logic [WIDTH-1:0]       core_x;
  logic [WIDTH-1:0]       core_y;
  logic                   core_done;
  logic [WIDTH-1:0]       core_result;

  modport slave (
    input  req, req_a, req_b, core_done, core_result,
    output gnt, rsp_valid, rsp_data, rsp_err, busy,
           core_rst_n, core_start, core_x, core_y
  );

  modport master (
    output req, req_a, req_b, core_done, core_result,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy,
           core_rst_n, core_start, core_x, core_y
  );
endinterface
`default_nettype wire

// File: rtl/gcd_job_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gcd_job_arbiter
//  Purpose  : Shares one GCD core among N_REQ requesters. A round-robin pick
//             chooses one requester per job, its operands are latched and
//             driven to the core, the core is run until done (or timeout) and
//             the result is returned to the winner. Zero operands are
//             answered with an error without starting the core.
//  Ports    : clk    system clock, rising edge
//             reset  synchronous, active-high
//             bus    gcd_job_arbiter_if.slave (requester + core signals)
//  Revision : 1.0  initial release
// ============================================================================
module gcd_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  wire logic         clk,
  input  wire logic         reset,
  gcd_job_arbiter_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] c_ptr_init = IW'(N_REQ - 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q,      state_d;
  logic [IW-1:0]    idx_q,        idx_d;
  logic [IW-1:0]    ptr_q,        ptr_d;
  logic [CW-1:0]    cnt_q,        cnt_d;
  logic [WIDTH-1:0] core_x_q,     core_x_d;
  logic [WIDTH-1:0] core_y_q,     core_y_d;
  logic [N_REQ-1:0] gnt_q,        gnt_d;
  logic [N_REQ-1:0] rsp_valid_q,  rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q,   rsp_data_d;
  logic             rsp_err_q,    rsp_err_d;
  logic             busy_q,       busy_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             core_start_q, core_start_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;

  // (base + off) mod N_REQ for off in 1..N_REQ, without a divider.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IW'(sum);
  endfunction

  // Round-robin scan: walking the offsets downward lets the nearest
  // requester after the pointer overwrite any farther one.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (bus.req[wrap_add(ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    busy_d       = busy_q;
    core_rst_n_d = core_rst_n_q;
    core_start_d = core_start_q;
    case (state_q)
      S_IDLE: begin
        core_rst_n_d = 1'b1;
        core_start_d = 1'b0;
        busy_d       = 1'b0;
        if (pick_found) begin
          idx_d           = pick_idx;
          ptr_d           = pick_idx;
          core_x_d        = bus.req_a[int'(pick_idx)*WIDTH +: WIDTH];
          core_y_d        = bus.req_b[int'(pick_idx)*WIDTH +: WIDTH];
          gnt_d[pick_idx] = 1'b1;
          busy_d          = 1'b1;
          state_d         = S_CHECK;
        end
      end
      S_CHECK: begin
        if (core_x_q == '0 || core_y_q == '0) begin
          // A zero operand would never converge; answer without the core.
          rsp_valid_d[idx_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_data_d         = '0;
          core_rst_n_d       = 1'b0;
          core_start_d       = 1'b0;
          state_d            = S_RESP;
        end else begin
          core_start_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        // done is tested first so it wins over a coincident timeout.
        if (bus.core_done) begin
          rsp_valid_d[idx_q] = 1'b1;
          rsp_err_d          = 1'b0;
          rsp_data_d         = bus.core_result;
          core_rst_n_d       = 1'b0;
          core_start_d       = 1'b0;
          state_d            = S_RESP;
        end else if (cnt_q == c_cnt_last) begin
          rsp_valid_d[idx_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_data_d         = '0;
          core_rst_n_d       = 1'b0;
          core_start_d       = 1'b0;
          state_d            = S_RESP;
        end
      end
      S_RESP: begin
        busy_d       = 1'b0;
        core_rst_n_d = 1'b1;
        core_start_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      ptr_q        <= c_ptr_init;
      cnt_q        <= '0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      core_rst_n_q <= core_rst_n_d;
      core_start_q <= core_start_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.core_start = core_start_q;
  assign bus.core_x     = core_x_q;
  assign bus.core_y     = core_y_q;

endmodule
`default_nettype wire
